eth_tx_arbiter: RTL

- Frame-level round-robin arbiter that shares one Ethernet transmit byte stream between NUM_SRC requesters.
- Sits upstream of the transmit FSM, which runs PREAMBLE..CRC32. It grants one source per frame and holds that grant from the first byte to the `last` byte.
- Enforces a programmable inter-packet gap (IPG) before the next grant.
- Presents a single valid/ready/last byte interface to the transmitter.

---
 rtl/eth_pkg.sv | 20 ++
 rtl/eth_rr_pick.sv | 46 ++++
 rtl/eth_tx_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eth_pkg
// Purpose  : Shared types and constants for the Ethernet transmit arbiter.
// Revision : 1.0  initial release
// ============================================================================
package eth_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int ETH_IFG_BYTES = 12;

endpackage
`default_nettype wire

// File: rtl/eth_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : eth_rr_pick
// Purpose  : Combinational round-robin picker; first request at or after
//            rr_ptr+1, wrapping, via a double-width masked priority encoder.
// Revision : 1.0  initial release
// ============================================================================
module eth_rr_pick
    import eth_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   rr_ptr,
    output logic [SRC_W-1:0]   winner,
    output logic               any_req
);

    localparam logic [SRC_W:0] c_num_src = (SRC_W+1)'(NUM_SRC);

    logic [2*NUM_SRC-1:0] w_dbl;
    logic [SRC_W-1:0]     w_start;
    logic [SRC_W:0]       w_idx;
    logic [SRC_W:0]       w_sub;

    assign w_dbl   = {req, req};
    assign w_start = (rr_ptr == SRC_W'(NUM_SRC - 1)) ? '0 : rr_ptr + SRC_W'(1);
    assign any_req = |req;

    // Scanning downward leaves the lowest unmasked set bit; the upper copy
    // of the request vector supplies the wrap-around candidates.
    always_comb begin
        w_idx = '0;
        for (int i = 2*NUM_SRC-1; i >= 0; i--) begin
            if (w_dbl[i] && (i >= int'(w_start))) begin
                w_idx = (SRC_W+1)'(i);
            end
        end
    end

    assign w_sub  = w_idx - c_num_src;
    assign winner = (w_idx >= c_num_src) ? w_sub[SRC_W-1:0] : w_idx[SRC_W-1:0];

endmodule
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : eth_tx_arbiter
// Purpose  : Frame-level round-robin arbiter feeding one Ethernet TX byte
//            stream, with a programmable inter-packet gap after each frame.
// Revision : 1.0  initial release
// ============================================================================
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int IFG_BYTES = ETH_IFG_BYTES,
    parameter int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC*8-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 tx_valid,
    output byte_t                tx_data,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic [SRC_W-1:0]     tx_src_id,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int                c_cnt_w    = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
    localparam logic [c_cnt_w-1:0] c_gap_load = (IFG_BYTES > 0) ? c_cnt_w'(IFG_BYTES - 1) : '0;
    localparam logic [SRC_W-1:0]   c_rr_init  = SRC_W'(NUM_SRC - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [SRC_W-1:0]   r_rr_ptr, w_rr_nxt;
    logic [SRC_W-1:0]   r_src_id, w_src_id_nxt;
    logic [c_cnt_w-1:0] r_gap_cnt, w_gap_nxt;
    logic               r_frame_done;

    logic [SRC_W-1:0]   w_winner;
    logic               w_any;
    logic               w_grant;
    logic               w_last_hs;

    eth_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req     (src_valid),
        .rr_ptr  (r_rr_ptr),
        .winner  (w_winner),
        .any_req (w_any)
    );

    assign w_grant = (r_state == GRANT);

    // The granted source is wired straight through; everything else is quiet.
    always_comb begin
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_last   = 1'b0;
        src_ready = '0;
        if (w_grant) begin
            tx_valid            = src_valid[r_src_id];
            tx_data             = src_data[{r_src_id, 3'b000} +: 8];
            tx_last             = src_last[r_src_id];
            src_ready[r_src_id] = tx_ready;
        end
    end

    assign w_last_hs  = tx_valid & tx_ready & tx_last;
    assign tx_src_id  = r_src_id;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr_ptr;
        w_src_id_nxt = r_src_id;
        w_gap_nxt    = r_gap_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt  = GRANT;
                    w_src_id_nxt = w_winner;
                end
            end
            GRANT: begin
                if (w_last_hs) begin
                    w_rr_nxt = r_src_id;
                    if (IFG_BYTES > 0) begin
                        w_gap_nxt   = c_gap_load;
                        w_state_nxt = GAP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - c_cnt_w'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_rr_ptr     <= c_rr_init;
            r_src_id     <= '0;
            r_gap_cnt    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rr_ptr     <= w_rr_nxt;
            r_src_id     <= w_src_id_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_frame_done <= w_last_hs;
        end
    end

endmodule
`default_nettype wire
